demap_ctrl: RTL
===============

# demap_ctrl

Frame-level sequencer for the subcarrier demapper/pilot-remover datapath in the 802.11a receive chain. It accepts equalized 52-bit subcarrier groups from the FFT/equalizer side over a valid/ready handshake and latches the frame's modulation. It drives the demapper's data, `run` and `mod` inputs through a registered stage, then packs the two 18-bit demapped words into a 36-bit output beat for the deinterleaver, tagged with beat/symbol boundary flags. Each OFDM symbol is 8 beats of 6 data subcarriers (48 data subcarriers).

## Interface
- `NSYM_W`, 10, width of symbol-count field (max frame 2^NSYM_W−1 symbols)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `frame_start`  in  1  single-cycle pulse; starts a frame (honoured in IDLE only)
- `frame_mod`  in  2  0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM; sampled with `frame_start`
- `frame_nsym`  in  NSYM_W  symbols in frame; sampled with `frame_start`
- `frame_abort`  in  1  synchronous abort, any state
- `in_data`  in  52  subcarrier group, 6×8-bit subcarriers in [47:0]; [51:48] ignored
- `in_valid`  in  1  upstream data valid
- `in_ready`  out  1  controller accepts `in_data` this cycle
- `dm_x`  out  52  registered data to demapper
- `dm_run`  out  1  registered run to demapper
- `dm_mod`  out  2  latched frame modulation to demapper
- `dm_x0`, `dm_x1`  in  18 each  demapper outputs (combinational from `dm_x`)
- `out_data`  out  36  {dm_x1, dm_x0} captured
- `out_nbits`  out  6  valid bits in `out_data`: 6, 12, 24, 36 for mod 0..3
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts beat
- `out_sym_last`  out  1  beat is beat 7 of its symbol
- `out_frame_last`  out  1  beat is last beat of last symbol
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse when last beat transfers

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE → RUN on `frame_start` with `frame_nsym` ≠ 0; latch mod and nsym, clear counters. `frame_start` with nsym = 0 is ignored.
- RUN: accept inputs. After the 8·nsym-th input transfer, go to DRAIN. `in_ready` is 0 in IDLE and DRAIN.
- DRAIN → IDLE when the last beat transfers on the output (`out_valid & out_ready & out_frame_last`). `frame_done` pulses in that cycle.
- Pipeline: stage A (`dm_x`, `dm_run`, beat/symbol tags) and stage B (the output registers).
- Advance when B is empty or `out_ready` = 1.
- `in_ready` = RUN & (A empty | advance).
- The input counter uses a beat index 0..7, wrapping to 0 and incrementing the symbol index on beat 7. Tags are computed at input acceptance and travel with the data.
- `dm_run` = stage-A valid. `dm_mod` holds the latched mod for the whole frame. Changes on `frame_mod` mid-frame have no effect.
- `out_nbits` is derived from the latched mod, not recomputed per beat.
- `frame_start` while busy is ignored.
- `frame_abort`: next cycle, the state is IDLE, both stage valids are 0, counters are 0 and no `frame_done` is issued. Abort has priority over a simultaneous `frame_start`.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; `dm_mod` 0.
- Latency: data accepted at edge N appears on `dm_x` after N. `out_data` is valid after edge N+1 (2 cycles in, first beat out).
- With `out_ready` held 1, throughput is 1 beat/cycle. A frame of S symbols takes 8S+2 cycles from the first accept to `frame_done`.
- Backpressure: while `out_valid & !out_ready`, stage B holds and stage A holds if valid. `out_data` and tags are stable until transfer.
- Simultaneous stage-B drain and stage-A fill in one cycle is legal and required.
- Reset asserted mid-frame: immediate return to reset values; no partial beat survives.

## Configuration
- `DEMAP_CTRL_CNT_EN` defined: adds the output port `beat_count` [15:0]. It counts output transfers since reset, is saturating at 16'hFFFF, is not cleared by abort, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- BPSK, nsym = 1, `in_valid`/`out_ready` held 1: 8 beats; `out_nbits` = 6; `out_sym_last` on beat 7 only; `out_frame_last` + `frame_done` on beat 7; `frame_done` at cycle 10 after the first accept.
- 64-QAM, nsym = 3, random `out_ready` (50%): exactly 24 beats in order; `out_data` matches the demapper model; `out_nbits` = 36; no beat lost or duplicated; outputs stable while stalled.
- QPSK frame_start with nsym = 0: `busy` stays 0 and `in_ready` stays 0. A second frame_start with nsym = 2 during RUN is ignored; only 16 beats are produced.
- 16-QAM, nsym = 2, assert `frame_abort` after 5 accepts: next cycle `busy` = 0 and `out_valid` = 0; no `frame_done`. A new frame then starts cleanly with beat index 0.
- Toggle `frame_mod` from 2 to 0 mid-frame: `dm_mod` stays 2 and `out_nbits` stays 24 for the whole frame.
- `DEMAP_CTRL_CNT_EN` build: two 64-QAM frames of nsym = 1 give `beat_count` = 16. Forcing the counter to 16'hFFFE and running 4 beats gives 16'hFFFF.

Source files
------------

// File: rtl/demap_ctrl.sv
// Frame sequencer for the subcarrier demapper: input handshake, registered demapper drive, packed
// output beats with symbol/frame tags. Define DEMAP_CTRL_CNT_EN to add the beat_count port.
module demap_ctrl #(
  parameter int unsigned NSYM_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [1:0]        frame_mod,
  input  logic [NSYM_W-1:0] frame_nsym,
  input  logic              frame_abort,
  input  logic [51:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [51:0]       dm_x,
  output logic              dm_run,
  output logic [1:0]        dm_mod,
  input  logic [17:0]       dm_x0,
  input  logic [17:0]       dm_x1,
  output logic [35:0]       out_data,
  output logic [5:0]        out_nbits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sym_last,
  output logic              out_frame_last,
  output logic              busy,
  output logic              frame_done
`ifdef DEMAP_CTRL_CNT_EN
  ,
  output logic [15:0]       beat_count
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mod_q, mod_d;
  logic [5:0]        nbits_q, nbits_d;
  logic [NSYM_W-1:0] last_sym_q, last_sym_d;
  logic [NSYM_W-1:0] sym_q, sym_d;
  logic [2:0]        beat_q, beat_d;
  logic              a_valid_q, a_valid_d;
  logic [51:0]       a_data_q, a_data_d;
  logic              a_sl_q, a_sl_d, a_fl_q, a_fl_d;
  logic              b_valid_q, b_valid_d;
  logic [35:0]       b_data_q, b_data_d;
  logic              b_sl_q, b_sl_d, b_fl_q, b_fl_d;
  logic              advance, accept, xfer, in_last;

  always_comb begin
    state_d    = state_q;
    mod_d      = mod_q;
    nbits_d    = nbits_q;
    last_sym_d = last_sym_q;
    sym_d      = sym_q;
    beat_d     = beat_q;
    a_valid_d  = a_valid_q;
    a_data_d   = a_data_q;
    a_sl_d     = a_sl_q;
    a_fl_d     = a_fl_q;
    b_valid_d  = b_valid_q;
    b_data_d   = b_data_q;
    b_sl_d     = b_sl_q;
    b_fl_d     = b_fl_q;

    advance    = !b_valid_q || out_ready;
    in_ready   = (state_q == StRun) && (!a_valid_q || advance);
    accept     = in_valid && in_ready;
    xfer       = b_valid_q && out_ready;
    in_last    = (beat_q == 3'd7) && (sym_q == last_sym_q);
    frame_done = xfer && b_fl_q && !frame_abort;

    // Stage B takes whatever stage A holds; A refills in the same cycle when a beat is accepted.
    if (advance) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_data_d = {dm_x1, dm_x0};
        b_sl_d   = a_sl_q;
        b_fl_d   = a_fl_q;
      end
    end
    if (accept) begin
      a_valid_d = 1'b1;
      a_data_d  = in_data;
      a_sl_d    = (beat_q == 3'd7);
      a_fl_d    = in_last;
      beat_d    = beat_q + 3'd1;
      if (beat_q == 3'd7) sym_d = sym_q + 1'b1;
    end else if (advance) begin
      a_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_start && (frame_nsym != '0)) begin
          state_d    = StRun;
          mod_d      = frame_mod;
          nbits_d    = (frame_mod == 2'd0) ? 6'd6  :
                       (frame_mod == 2'd1) ? 6'd12 :
                       (frame_mod == 2'd2) ? 6'd24 : 6'd36;
          last_sym_d = frame_nsym - 1'b1;
          beat_d     = '0;
          sym_d      = '0;
        end
      end
      StRun: begin
        if (accept && in_last) state_d = StDrain;
      end
      StDrain: begin
        if (frame_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (frame_abort) begin
      state_d   = StIdle;
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
      beat_d    = '0;
      sym_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mod_q      <= '0;
      nbits_q    <= '0;
      last_sym_q <= '0;
      sym_q      <= '0;
      beat_q     <= '0;
      a_valid_q  <= 1'b0;
      a_data_q   <= '0;
      a_sl_q     <= 1'b0;
      a_fl_q     <= 1'b0;
      b_valid_q  <= 1'b0;
      b_data_q   <= '0;
      b_sl_q     <= 1'b0;
      b_fl_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mod_q      <= mod_d;
      nbits_q    <= nbits_d;
      last_sym_q <= last_sym_d;
      sym_q      <= sym_d;
      beat_q     <= beat_d;
      a_valid_q  <= a_valid_d;
      a_data_q   <= a_data_d;
      a_sl_q     <= a_sl_d;
      a_fl_q     <= a_fl_d;
      b_valid_q  <= b_valid_d;
      b_data_q   <= b_data_d;
      b_sl_q     <= b_sl_d;
      b_fl_q     <= b_fl_d;
    end
  end

  assign dm_x           = a_data_q;
  assign dm_run         = a_valid_q;
  assign dm_mod         = mod_q;
  assign out_data       = b_data_q;
  assign out_nbits      = nbits_q;
  assign out_valid      = b_valid_q;
  assign out_sym_last   = b_sl_q;
  assign out_frame_last = b_fl_q;
  assign busy           = (state_q != StIdle);

`ifdef DEMAP_CTRL_CNT_EN
  // Lifetime transfer count: survives aborts, saturates instead of wrapping.
  logic [15:0] beat_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count_q <= '0;
    end else if (xfer && (beat_count_q != 16'hFFFF)) begin
      beat_count_q <= beat_count_q + 16'd1;
    end
  end

  assign beat_count = beat_count_q;
`endif

endmodule
